// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer clock divider giving a 50% duty output for even and odd divisors.
// A divisor change waits for an output period boundary, so clk_out never glitches.
module clk_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] div_cur
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_pend;
    logic             pend;
    logic             pos_q;
    logic             neg_q;
    logic             tick_q;
    logic             err_q;

    logic [CNT_W-1:0] n_sel;
    logic [CNT_W-1:0] n_next;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             boundary;
    logic             load_ok;
    logic             load_bad;
    logic             pos_next;
    logic             tick_next;

    // High phase in posedge counts is ceil(n/2); one bit wider so n = 2^CNT_W-1 cannot overflow.
    function automatic logic [CNT_W:0] half_len(input logic [CNT_W-1:0] n);
        logic [CNT_W:0] n_w;
        n_w = {1'b0, n} + {{CNT_W{1'b0}}, 1'b1};
        return n_w >> 1;
    endfunction

    always_comb begin
        wrap     = (cnt == n_act - ONE);
        boundary = wrap || !en;
        n_sel    = pend ? n_pend : n_act;
        load_ok  = div_load && (div_val >= TWO);
        load_bad = div_load && (div_val < TWO);
        n_next   = n_act;
        cnt_next = cnt + ONE;
        if (!en) begin
            // Park one count before the boundary so the next enabled edge starts a fresh period.
            n_next   = n_sel;
            cnt_next = n_sel - ONE;
        end else if (wrap) begin
            n_next   = n_sel;
            cnt_next = '0;
        end
        pos_next  = en && ({1'b0, cnt_next} < half_len(n_next));
        tick_next = en && (cnt_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= DEF_N - ONE;
            n_act  <= DEF_N;
            n_pend <= DEF_N;
            pend   <= 1'b0;
            pos_q  <= 1'b0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            n_act  <= n_next;
            pos_q  <= pos_next;
            tick_q <= tick_next;
            err_q  <= load_bad;
            // A load landing on a boundary edge stays pending for the following boundary.
            if (load_ok) begin
                n_pend <= div_val;
                pend   <= 1'b1;
            end else if (boundary) begin
                pend   <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Odd divisors: delaying the rise by half a cycle trims the high phase to N/2 periods.
    assign clk_out = n_act[0] ? (pos_q & neg_q) : pos_q;
    assign tick    = tick_q;
    assign busy    = pend;
    assign err     = err_q;
    assign div_cur = n_act;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Randomised bench for clk_divider_prog: each window is compared half-cycle by half-cycle
// against a period-level model of the divided clock, strobe and divisor bookkeeping.
module tb_clk_divider_prog;

    localparam int CNT_W    = 8;
    localparam int DEF_DIV  = 2;
    localparam int MAXH     = 4096;
    localparam int SYNC_LIM = 600;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [CNT_W-1:0] div_val  = '0;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] div_cur;

    int n_checks = 0;
    int n_fails  = 0;
    int nh       = 0;
    int cur_n    = DEF_DIV;

    // Sample layout: {clk_out, tick, busy, err, div_cur[7:0]}
    logic [11:0] got_v [MAXH];
    logic [11:0] exp_v [MAXH];

    clk_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .err      (err),
        .div_cur  (div_cur)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Period-level model. Cycle 0 is the first cycle of a period with divisor n_old.
    // Loads are sampled at the posedge opening cycle c; en is low for cycles d..r-1.
    task automatic build_model(input int n_old, input int c1, input int v1, input int c2,
                               input int v2, input int d, input int r, input int ncyc);
        int s = 0;
        int n = n_old;
        int pv = 0;
        int p;
        bit pend = 1'b0;
        bit off;
        bit hi;
        bit er;
        for (int j = 0; j < ncyc; j++) begin
            off = (d >= 0) && (j >= d) && (j < r);
            if (off || j == r || j == s + n) begin
                if (pend) begin
                    n    = pv;
                    pend = 1'b0;
                end
                if (!off) s = j;
            end
            if (j == c1 && v1 >= 2) begin pend = 1'b1; pv = v1; end
            if (j == c2 && v2 >= 2) begin pend = 1'b1; pv = v2; end
            er = (j == c1 && v1 < 2) || (j == c2 && v2 < 2);
            for (int k = 0; k < 2; k++) begin
                p  = 2 * (j - s) + k;
                hi = !off && ((n % 2 == 0) ? (p < n) : (p >= 1 && p <= n));
                exp_v[2*j+k] = {hi, !off && (j == s), pend, er, 8'(n)};
            end
        end
        nh    = 2 * ncyc;
        cur_n = n;
    endtask

    // Aligns to a period start (tick seen after a posedge), then drives and samples each half cycle.
    task automatic run_window(input int n_old, input int c1, input int v1, input int c2,
                              input int v2, input int d, input int r, input int ncyc);
        bit found = 1'b0;
        int j;
        build_model(n_old, c1, v1, c2, v2, d, r, ncyc);
        for (int i = 0; i < SYNC_LIM && !found; i++) begin
            @(posedge clk); #1;
            found = (tick === 1'b1);
        end
        if (!found) begin
            for (int h = 0; h < nh; h++) got_v[h] = 'x;
            return;
        end
        for (int h = 0; h < nh; h++) begin
            got_v[h] = {clk_out, tick, busy, err, div_cur};
            if (h % 2 == 0) begin
                j = h / 2;
                div_load = 1'b0;
                if (j + 1 == c1) begin div_load = 1'b1; div_val = 8'(v1); end
                if (j + 1 == c2) begin div_load = 1'b1; div_val = 8'(v2); end
                if (d >= 0 && j + 1 == d) en = 1'b0;
                if (r >= 0 && j + 1 == r) en = 1'b1;
            end
            @(clk); #1;
        end
        div_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        div_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (clk_out !== 1'b0) begin n_fails++; $display("FAIL reset clk_out: got %b expected 0", clk_out); end
        n_checks++;
        if (tick !== 1'b0) begin n_fails++; $display("FAIL reset tick: got %b expected 0", tick); end
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++;
        if (err !== 1'b0) begin n_fails++; $display("FAIL reset err: got %b expected 0", err); end
        n_checks++;
        if (div_cur !== 8'(DEF_DIV)) begin n_fails++; $display("FAIL reset div_cur: got %0d expected %0d", div_cur, DEF_DIV); end
        @(negedge clk);
        rst_n = 1'b1;
        cur_n = DEF_DIV;
    endtask

    task automatic test_default();
        int bc = -1;
        int bt = -1;
        run_window(cur_n, -1, 0, -1, 0, -1, -1, 12);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL default clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL default tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_even_load();
        int bc = -1;
        int bt = -1;
        int c = $urandom_range(1, cur_n);
        int w = (c / cur_n + 1) * cur_n;
        run_window(cur_n, c, 6, -1, 0, -1, -1, w + 14);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL even_load clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL even_load tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_odd_load();
        int bc = -1;
        int bt = -1;
        int c = $urandom_range(1, cur_n);
        int w = (c / cur_n + 1) * cur_n;
        run_window(cur_n, c, 5, -1, 0, -1, -1, w + 15);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL odd_load clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL odd_load tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_rejected();
        int bc = -1;
        int bt = -1;
        int c = $urandom_range(1, 3);
        run_window(cur_n, c, 0, c + 2, 1, -1, -1, 2 * cur_n + c + 4);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL rejected clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL rejected tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_overwrite();
        int bc = -1;
        int bt = -1;
        int c1 = $urandom_range(1, 2);
        int c2 = c1 + $urandom_range(1, 2);
        int w = (c1 / cur_n + 1) * cur_n;
        run_window(cur_n, c1, 4, c2, 7, -1, -1, w + 16);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL overwrite clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL overwrite tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_max_div();
        int vals [2] = '{255, 3};
        int bc;
        int bt;
        int c;
        int w;
        for (int k = 0; k < 2; k++) begin
            bc = -1;
            bt = -1;
            c = $urandom_range(1, cur_n);
            w = (c / cur_n + 1) * cur_n;
            run_window(cur_n, c, vals[k], -1, 0, -1, -1, w + 2 * vals[k] + 2);
            for (int h = 0; h < nh; h++) begin
                if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
                if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
            end
            n_checks += 2;
            if (bc >= 0) begin n_fails++; $display("FAIL max_div_%0d clk_out half %0d: got %b expected %b", vals[k], bc, got_v[bc][11], exp_v[bc][11]); end
            if (bt >= 0) begin n_fails++; $display("FAIL max_div_%0d tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", vals[k], bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
        end
    endtask

    task automatic test_enable();
        int bc;
        int bt;
        int c;
        int v;
        int w;
        int d;
        int r;
        for (int sc = 0; sc < 2; sc++) begin
            bc = -1;
            bt = -1;
            if (sc == 0) begin
                c = 1;
                v = 8;
                w = (c / cur_n + 1) * cur_n;
                d = w + $urandom_range(1, 3);
                r = d + $urandom_range(1, 4);
            end else begin
                c = 2;
                v = 4;
                d = 4;
                r = 7;
            end
            run_window(cur_n, c, v, -1, 0, d, r, r + 2 * v + 2);
            for (int h = 0; h < nh; h++) begin
                if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
                if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
            end
            n_checks += 2;
            if (bc >= 0) begin n_fails++; $display("FAIL enable_%0d clk_out half %0d: got %b expected %b", sc, bc, got_v[bc][11], exp_v[bc][11]); end
            if (bt >= 0) begin n_fails++; $display("FAIL enable_%0d tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", sc, bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int bc = -1;
        int bt = -1;
        for (int i = 0; i < SYNC_LIM && !found; i++) begin
            @(posedge clk); #1;
            found = (tick === 1'b1);
        end
        n_checks++;
        if (!found) begin n_fails++; $display("FAIL reset_mid sync: got no tick, expected one within %0d cycles", SYNC_LIM); end
        div_load = 1'b1;
        div_val  = 8'd9;
        @(posedge clk); #1;
        div_load = 1'b0;
        n_checks++;
        if ({clk_out, busy} !== 2'b11) begin n_fails++; $display("FAIL reset_mid before: got clk_out,busy=%b expected 11", {clk_out, busy}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (clk_out !== 1'b0) begin n_fails++; $display("FAIL reset_mid clk_out: got %b expected 0", clk_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
        n_checks++;
        if (div_cur !== 8'(DEF_DIV)) begin n_fails++; $display("FAIL reset_mid div_cur: got %0d expected %0d", div_cur, DEF_DIV); end
        n_checks++;
        if (tick !== 1'b0) begin n_fails++; $display("FAIL reset_mid tick: got %b expected 0", tick); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur_n = DEF_DIV;
        run_window(cur_n, -1, 0, -1, 0, -1, -1, 10);
        for (int h = 0; h < nh; h++) begin
            if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
            if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
        end
        n_checks += 2;
        if (bc >= 0) begin n_fails++; $display("FAIL reset_mid restart clk_out half %0d: got %b expected %b", bc, got_v[bc][11], exp_v[bc][11]); end
        if (bt >= 0) begin n_fails++; $display("FAIL reset_mid restart tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
    endtask

    task automatic test_random();
        int bc;
        int bt;
        int nv;
        int c;
        int w;
        for (int it = 0; it < 8; it++) begin
            bc = -1;
            bt = -1;
            nv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
            c  = $urandom_range(1, cur_n);
            w  = (c / cur_n + 1) * cur_n;
            run_window(cur_n, c, nv, -1, 0, -1, -1, w + 2 * ((nv >= 2) ? nv : cur_n) + 2);
            for (int h = 0; h < nh; h++) begin
                if (bc < 0 && got_v[h][11] !== exp_v[h][11]) bc = h;
                if (bt < 0 && got_v[h][10:0] !== exp_v[h][10:0]) bt = h;
            end
            n_checks += 2;
            if (bc >= 0) begin n_fails++; $display("FAIL random_%0d (load %0d) clk_out half %0d: got %b expected %b", it, nv, bc, got_v[bc][11], exp_v[bc][11]); end
            if (bt >= 0) begin n_fails++; $display("FAIL random_%0d (load %0d) tick/busy/err half %0d: got %b div_cur=%0d expected %b div_cur=%0d", it, nv, bt, got_v[bt][10:8], got_v[bt][7:0], exp_v[bt][10:8], exp_v[bt][7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_even_load();
        test_odd_load();
        test_rejected();
        test_overwrite();
        test_max_div();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Runtime-programmable integer clock divider producing a 50%-duty divided clock for any divisor N from 2 to 2^CNT_W-1, including odd N. It generalises the fixed divide-by-2 toggler used across the design. It adds:
- a parametrised counter width
- a glitch-free divisor change, applied only at a period boundary
- an enable
- an asynchronous reset
- a per-period strobe for synchronous logic in the source domain

## Interface
- CNT_W, 8, width of counter and divisor; maximum divisor 2^CNT_W-1
- DEFAULT_DIV, 2, divisor active after reset; must be in 2..2^CNT_W-1
- clk  input  1  source clock; the block uses both edges
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run enable, sampled on posedge clk
- div_val  input  CNT_W  requested divisor, sampled when div_load=1
- div_load  input  1  single-cycle load request
- clk_out  output  1  divided clock
- tick  output  1  one-cycle strobe, high during the first clk cycle of each output period
- busy  output  1  a validated divisor is pending and not yet applied
- err  output  1  one-cycle pulse: the last load was rejected (div_val < 2)
- div_cur  output  CNT_W  divisor currently in effect

## Operation
- Registers:
  - cnt (CNT_W)
  - n_act (active divisor)
  - n_pend plus pend flag
  - pos_q (posedge flop)
  - neg_q (negedge flop)
- H = ceil(N/2), computed as (N+1)>>1 in CNT_W+1 bits so N = 2^CNT_W-1 does not overflow.
- Wrap edge: an enabled posedge with cnt == n_act-1. On it:
  - cnt <= 0
  - if pend: n_act <= n_pend, pend <= 0
- Other enabled posedges: cnt <= cnt+1.
- pos_q <= (cnt_next < H), where H is taken from the n_act in effect for cnt_next.
- neg_q <= pos_q on every negedge clk.
- clk_out:
  - N even: clk_out = pos_q
  - N odd: clk_out = pos_q & neg_q (high for exactly N/2 clk periods)
- tick = registered (cnt_next == 0 && en); it is high during the cycle after the wrap edge.
- en = 0 at a posedge:
  - pos_q <= 0 and cnt <= n_act-1, so the next enabled edge starts a fresh period.
  - A truncated high pulse is permitted.
  - A pending divisor is applied immediately.
- div_load with div_val >= 2: n_pend <= div_val, pend <= 1.
  - A load while pend is set overwrites n_pend (last wins).
- div_load with div_val < 2: err = 1 for the next cycle; n_pend, pend and n_act are unchanged.
- A load on the same edge as a wrap is not applied at that wrap; it becomes pending for the following wrap.
- busy = pend. div_cur = n_act.

## Timing
- Reset values (asynchronous, immediate):
  - cnt = DEFAULT_DIV-1, n_act = DEFAULT_DIV, pend = 0
  - pos_q = 0, neg_q = 0, clk_out = 0
  - tick = 0, busy = 0, err = 0
- Start-up: the first enabled posedge after rst_n rises is a wrap edge.
  - Even N: clk_out rises at that edge.
  - Odd N: clk_out rises at the following negedge.
- Period: exactly N clk cycles.
- Duty:
  - even N: high N/2 cycles
  - odd N: high (N-1)/2 + 0.5 cycles; rises on a negedge, falls on a posedge
- Divisor change: clk_out is glitch-free. The new N is effective from the first wrap edge after busy rises (worst case N_old cycles). busy falls on that wrap edge.
- err: asserted in the cycle after the rejected load.
- Reset mid-period: clk_out is forced low asynchronously. Restart follows the start-up rule with DEFAULT_DIV.

## Test plan
- Default divisor: reset, en=1, no loads, DEFAULT_DIV=2 → clk_out period 2 clk, high 1; tick every 2 cycles; div_cur=2; busy=0.
- Even load: load 6 mid-period → busy=1 until the next wrap; then clk_out high 3 / low 3; div_cur=6 from that wrap; no short or long pulse at the switch.
- Odd load: load 5 → clk_out rises 0.5 cycle after the wrap posedge and falls 3 posedges after the wrap, giving 2.5 high / 2.5 low with period 5; tick every 5 cycles.
- Rejected and overwritten loads:
  - load 0, then load 1 → err pulses once each; div_cur unchanged; busy stays 0.
  - load 4 then load 7 before the wrap → 7 is applied.
- Maximum divisor: CNT_W=8, load 255 → period 255, high 127.5 cycles, no overflow. Also load 3 → high 1.5 cycles.
- Enable and reset: drop en mid-high → clk_out low within 1 cycle. Raise en → new period starts at the first edge. Assert rst_n=0 mid-period with pend=1 → clk_out=0, busy=0, div_cur=DEFAULT_DIV immediately.
